prewitt_hor_stream: RTL
=======================

Name: prewitt_hor_stream

Overview:
Streaming, synthesizable receiver-side counterpart of the image pipeline's batch Prewitt-horizontal stage. It consumes a raster-order 8-bit pixel stream with a valid/ready handshake and start-of-frame marker, and computes the horizontal Prewitt magnitude per pixel using internal line buffers. It emits a raster-order result stream with sof/eol/eof markers, and forces border pixels to 0. It sits between the pixel source (file reader or camera front end) and the output frame writer.

Parameters:
ROWS, 242, frame height in pixels; must be >= 3
COLS, 247, frame width in pixels; must be >= 3

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input pixel valid
in_ready  output  1  block accepts input this cycle
in_data  input  8  input pixel, unsigned
in_sof  input  1  marks first pixel of a frame
out_valid  output  1  output pixel valid
out_ready  input  1  downstream accepts output
out_data  output  8  edge magnitude, saturated 0..255
out_sof  output  1  with out_valid: pixel (0,0)
out_eol  output  1  with out_valid: column COLS-1
out_eof  output  1  with out_valid: pixel (ROWS-1,COLS-1)
frame_err  output  1  one-cycle pulse: in_sof seen mid-frame

Behaviour:
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Reset (rst=0, asynchronous): state IDLE; counters 0; out_valid=0, out_data=0, out_sof/eol/eof=0, frame_err=0; in_ready=1. Line-buffer contents are don't-care.
- Mid-operation reset: abort immediately. Any partial frame is discarded and no further outputs are produced.
- Output register: single stage. in_ready = 1 in IDLE and FILL. In RUN, in_ready = !out_valid | out_ready. In FLUSH, in_ready = 0.
- States:
  - IDLE: pixels without in_sof are accepted and dropped. An accepted pixel with in_sof is input index 0 -> FILL.
  - FILL: accept input indices 0..COLS. No output in this state. After index COLS is accepted -> RUN.
  - RUN: each accepted input index k+COLS+1 loads output index k into the output register. After input index ROWS*COLS-1 is accepted -> FLUSH.
  - FLUSH: emit the remaining COLS+1 outputs, all value 0 because they are border pixels. One output per cycle when the output register is free. After out_eof transfers -> IDLE.
- Latency: out_valid rises the cycle after the accepting edge of input index k+COLS+1.
- Output pixel (r,c), k = r*COLS+c:
  - If r==0, r==ROWS-1, c==0 or c==COLS-1: value 0.
  - Otherwise: sx = (p[r-1][c-1]+p[r][c-1]+p[r+1][c-1]) - (p[r-1][c+1]+p[r][c+1]+p[r+1][c+1]).
  - Each column sum is 10-bit unsigned; sx is 11-bit signed.
  - out_data = min(|sx|, 255). No vertical term.
- Markers: out_sof, out_eol and out_eof are combinational on the output index and held stable with out_data while out_valid=1 and out_ready=0.
- Backpressure: out_valid, out_data and the markers are held stable until the output transfers. No input is accepted in RUN while the output is stalled.
- in_sof when not IDLE: frame_err pulses for one cycle. The pixel is treated as an ordinary pixel; the frame is not restarted.
- in_valid=0 gaps are allowed anywhere. Counters advance only on transfers.
- Back-to-back frames: a new in_sof is accepted only after return to IDLE. Before that, in_ready=0 in FLUSH.

Test Plan:
1. ROWS=4, COLS=5, ramp p[r][c]=10*c, out_ready=1.
   - Rows 1-2, cols 1-3 = 60; all other outputs 0.
   - Exactly 20 outputs; sof on k=0, eol on k=4,9,14,19, eof on k=19.
2. ROWS=4, COLS=5, step image: cols 0-1 = 0, cols 2-4 = 100.
   - Interior cols 1,2 = 255 (|sx|=300, saturated); col 3 = 0.
3. Same ramp with out_ready toggling 1,0,0,1 and random in_valid gaps.
   - Identical output sequence to scenario 1.
   - Outputs never change while stalled; no pixel is dropped or duplicated.
4. Three pixels without in_sof, then a full frame.
   - The first three pixels are dropped; output matches a clean frame.
   - in_sof asserted at input index 7 -> frame_err pulses once and the output count is unchanged.
5. rst asserted low during RUN at input index 12.
   - out_valid=0 immediately; state is IDLE.
   - A subsequent full frame produces the correct 20 outputs.
6. Two frames back-to-back, the second with pixel values 255.
   - in_ready=0 during FLUSH of frame 1.
   - All frame-2 outputs are 0: uniform input gives sx=0.

Source files
------------

// File: rtl/prewitt_hor_stream_if.sv
// Stream bundle for prewitt_hor_stream: raster pixel input side plus result output side.
// Latency: pure wiring, none. The master modport is the edge block, which sinks
// pixels and sources results; the slave modport is the surrounding pipeline.
// Backpressure: valid/ready on each side; frame_err is an unqualified status pulse.
interface prewitt_hor_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       frame_err;

  modport master (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_err
  );

  modport slave (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_err
  );
endinterface

// File: rtl/prewitt_hor_stream.sv
// Streaming horizontal Prewitt magnitude, min(|left col sum - right col sum|, 255), borders forced to 0.
// Latency: output k is valid the cycle after input k+COLS+1 is accepted; the last COLS+1 outputs drain in FLUSH.
// Backpressure: one output register; in RUN input stalls while the result is held, in FLUSH input is refused.
//
// Ports: clk, rst (async, active low); io (master modport):
//   in_valid/in_ready/in_data/in_sof   raster pixel stream, in_sof on pixel (0,0)
//   out_valid/out_ready/out_data       result stream, out_sof/out_eol/out_eof mark (0,0), col COLS-1, last pixel
//   frame_err                          one-cycle pulse when in_sof arrives mid-frame
module prewitt_hor_stream #(
  parameter int ROWS = 242,  // frame height, >= 3
  parameter int COLS = 247   // frame width, >= 3
) (
  input  logic                 clk,
  input  logic                 rst,
  prewitt_hor_stream_if.master io
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } pos_t;

  // Raster increment, wrapping to (0,0) after the last pixel of the frame.
  function automatic pos_t pos_inc(input pos_t p);
    pos_t n;
    n = p;
    if (p.col == COL_LAST) begin
      n.col = '0;
      n.row = (p.row == ROW_LAST) ? '0 : p.row + 1'b1;
    end else begin
      n.col = p.col + 1'b1;
    end
    return n;
  endfunction

  function automatic logic pos_is_last(input pos_t p);
    return (p.row == ROW_LAST) && (p.col == COL_LAST);
  endfunction

  state_t     state_q, state_d;
  pos_t       in_pos_q;   // raster position of the next input pixel
  pos_t       ld_pos_q;   // position of the next result to load into the output register
  pos_t       out_pos_q;  // position of the result currently held
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       frame_err_q;
  logic [9:0] cs1_q, cs2_q;  // column sums of the previous two accepted pixels

  // Two previous rows at each column: lb1 = row above, lb2 = two rows above.
  logic [7:0] lb1 [COLS];
  logic [7:0] lb2 [COLS];

  logic        in_ready_c;
  logic        in_xfer;
  logic        pix_take;
  logic        out_free;
  logic        held_last;
  logic        load;
  logic [7:0]  load_data;
  logic [7:0]  lb_up1, lb_up2;
  logic [9:0]  col_sum;
  logic [10:0] sx;
  logic [10:0] mag;
  logic [7:0]  sat;
  logic        border;

  assign in_xfer   = io.in_valid & in_ready_c;
  // Pixels seen in IDLE without in_sof are dropped and must not touch the window.
  assign pix_take  = in_xfer & ((state_q != IDLE) | io.in_sof);
  assign out_free  = ~out_valid_q | io.out_ready;
  assign held_last = pos_is_last(out_pos_q);

  // The incoming pixel is the bottom-right corner of the window of output
  // (row-1, col-1); its column sum is the right-hand term, and the sum two
  // accepted pixels back (cs2_q) is the left-hand term.
  assign lb_up1  = lb1[in_pos_q.col];
  assign lb_up2  = lb2[in_pos_q.col];
  assign col_sum = {2'b00, io.in_data} + {2'b00, lb_up1} + {2'b00, lb_up2};
  assign sx      = {1'b0, cs2_q} - {1'b0, col_sum};
  assign mag     = sx[10] ? (~sx + 11'd1) : sx;
  assign sat     = (mag[10:8] != 3'd0) ? 8'hFF : mag[7:0];

  assign border = (ld_pos_q.row == '0) || (ld_pos_q.row == ROW_LAST) ||
                  (ld_pos_q.col == '0) || (ld_pos_q.col == COL_LAST);

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    load_data  = 8'd0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_xfer && io.in_sof) state_d = FILL;
      end
      FILL: begin
        in_ready_c = 1'b1;
        // Input index COLS is (row 1, col 0); the next pixel produces output 0.
        if (in_xfer && (in_pos_q.row == RW'(1)) && (in_pos_q.col == '0)) state_d = RUN;
      end
      RUN: begin
        in_ready_c = out_free;
        load       = in_xfer;
        load_data  = border ? 8'd0 : sat;
        if (in_xfer && pos_is_last(in_pos_q)) state_d = FLUSH;
      end
      FLUSH: begin
        // Remaining outputs are the bottom border; stop loading once the last is held.
        load = out_free & ~(out_valid_q & held_last);
        if (out_valid_q && io.out_ready && held_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_pos_q    <= '0;
      ld_pos_q    <= '0;
      out_pos_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      frame_err_q <= 1'b0;
      cs1_q       <= 10'd0;
      cs2_q       <= 10'd0;
    end else begin
      frame_err_q <= in_xfer & io.in_sof & (state_q != IDLE);
      if (pix_take) begin
        in_pos_q <= pos_inc(in_pos_q);
        cs1_q    <= col_sum;
        cs2_q    <= cs1_q;
      end
      if (load) begin
        ld_pos_q    <= pos_inc(ld_pos_q);
        out_pos_q   <= ld_pos_q;
        out_data_q  <= load_data;
        out_valid_q <= 1'b1;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Line buffer contents are don't-care after reset: stale rows only feed border outputs.
  always_ff @(posedge clk) begin
    if (pix_take) begin
      lb1[in_pos_q.col] <= io.in_data;
      lb2[in_pos_q.col] <= lb_up1;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_sof   = out_valid_q & (out_pos_q.row == '0) & (out_pos_q.col == '0);
  assign io.out_eol   = out_valid_q & (out_pos_q.col == COL_LAST);
  assign io.out_eof   = out_valid_q & held_last;
  assign io.frame_err = frame_err_q;
endmodule
